// File: rtl/ycc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ycc_pkg
//  Description : Shared constants and types for the YCbCr -> RGB stream
//                converter: default fixed-point precision, JFIF full-range
//                coefficients, default frame size and the RGB888 pixel type.
//  Revision    : 1.0  initial release
// ============================================================================
package ycc_pkg;

    // Default coefficient fraction bits and frame size (800x480 LCD).
    localparam int YCC_FRAC_BITS    = 10;
    localparam int YCC_FRAME_PIXELS = 384000;

    // Rounds num/den * 2^frac to the nearest integer. Lets the converter
    // derive its coefficients for any fraction width from the exact JFIF
    // ratios instead of carrying one hand-tuned table per precision.
    function automatic int ycc_coef(input longint num, input longint den, input int frac);
        return int'((num * (longint'(1) << frac) + den / 2) / den);
    endfunction

    // JFIF coefficients at the default precision (1436, 352, 731, 1815).
    localparam int YCC_KR  = ycc_coef(1402,   1000,    YCC_FRAC_BITS);
    localparam int YCC_KGB = ycc_coef(344136, 1000000, YCC_FRAC_BITS);
    localparam int YCC_KGR = ycc_coef(714136, 1000000, YCC_FRAC_BITS);
    localparam int YCC_KB  = ycc_coef(1772,   1000,    YCC_FRAC_BITS);

    // Packs as {R[23:16], G[15:8], B[7:0]}, matching the LCD video port.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage
`default_nettype wire

// File: rtl/ycc_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : ycc_frame_checker
//  Description : Tracks the pixel index of accepted input pixels and raises a
//                sticky error when sop/eop disagree with the frame size.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          system clock
//    reset_n      asynchronous active-low reset
//    i_accept     an input pixel is transferred this cycle
//    i_sop/i_eop  framing flags of that pixel
//    i_err_clr    clears the sticky error (an error event wins)
//    o_frame_err  sticky framing error
// ============================================================================
module ycc_frame_checker
    import ycc_pkg::*;
#(
    parameter int FRAME_PIXELS = YCC_FRAME_PIXELS
)(
    input  logic clk,
    input  logic reset_n,
    input  logic i_accept,
    input  logic i_sop,
    input  logic i_eop,
    input  logic i_err_clr,
    output logic o_frame_err
);

    localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(FRAME_PIXELS - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_frame_err;
    logic          w_at_first;
    logic          w_at_last;
    logic          w_err_evt;

    assign w_at_first = (r_cnt == '0);
    assign w_at_last  = (r_cnt == c_LAST);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_evt = 1'b0;
        if (i_accept) begin
            // sop belongs only on index 0, eop only on the last index.
            w_err_evt = (i_sop != w_at_first) || (i_eop != w_at_last);
            // eop always closes the frame. A sop resynchronises the count
            // (it marks index 0, so the next pixel is index 1); reaching
            // the last index without eop also closes the frame.
            if (i_eop) begin
                w_cnt_nxt = '0;
            end else if (i_sop) begin
                w_cnt_nxt = CW'(1);
            end else if (w_at_last) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_err_evt) begin
                r_frame_err <= 1'b1;
            end else if (i_err_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ycc_to_rgb_stream.sv
`default_nettype none
// ============================================================================
//  Module      : ycc_to_rgb_stream
//  Description : Three-stage YCbCr (JFIF full range) to RGB888 converter,
//                one pixel per clock, valid/ready on both sides with a
//                bubble-collapsing combinational ready path, plus a framing
//                checker on the input handshake.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, reset_n                 clock, async active-low reset
//    in_valid/in_ready            input handshake
//    in_y/in_cb/in_cr             8-bit unsigned samples
//    in_sop/in_eop                frame start / end flags
//    out_valid/out_ready          output handshake
//    out_rgb                      {R,G,B}, held while stalled
//    out_sop/out_eop              framing aligned with out_rgb
//    frame_err/err_clr            sticky framing error and its clear
//    frame_done                   pulse the cycle after an eop output transfer
// ============================================================================
module ycc_to_rgb_stream
    import ycc_pkg::*;
#(
    parameter int FRAC_BITS    = YCC_FRAC_BITS,
    parameter int FRAME_PIXELS = YCC_FRAME_PIXELS
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_y,
    input  logic [7:0]  in_cb,
    input  logic [7:0]  in_cr,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb,
    output logic        out_sop,
    output logic        out_eop,
    output logic        frame_err,
    input  logic        err_clr,
    output logic        frame_done
);

    // 8 integer bits of Y, plus headroom for the largest coefficient sum
    // and a sign bit.
    localparam int W = FRAC_BITS + 12;

    localparam logic signed [W-1:0] c_KR   = W'(ycc_coef(1402,   1000,    FRAC_BITS));
    localparam logic signed [W-1:0] c_KGB  = W'(ycc_coef(344136, 1000000, FRAC_BITS));
    localparam logic signed [W-1:0] c_KGR  = W'(ycc_coef(714136, 1000000, FRAC_BITS));
    localparam logic signed [W-1:0] c_KB   = W'(ycc_coef(1772,   1000,    FRAC_BITS));
    localparam logic signed [W-1:0] c_HALF = W'(longint'(1) << (FRAC_BITS - 1));

    // Clamp a signed integer result to 0..255.
    function automatic logic [7:0] f_sat(input logic signed [W-1:0] v);
        if (v[W-1]) begin
            return 8'h00;
        end else if (|v[W-2:8]) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // Handshake / stage advance
    // ------------------------------------------------------------------
    logic w_adv_out;
    logic w_adv_s2;
    logic w_adv_s1;
    logic w_in_fire;

    logic r_s1_v;
    logic r_s2_v;
    logic r_out_v;

    assign w_adv_out = !r_out_v || out_ready;
    assign w_adv_s2  = !r_s2_v  || w_adv_out;
    assign w_adv_s1  = !r_s1_v  || w_adv_s2;
    assign in_ready  = w_adv_s1;
    assign w_in_fire = in_valid && w_adv_s1;

    // ------------------------------------------------------------------
    // S1: Y and chroma offsets
    // ------------------------------------------------------------------
    logic [7:0]        r_s1_y;
    logic signed [8:0] r_s1_dcb;
    logic signed [8:0] r_s1_dcr;
    logic              r_s1_sop;
    logic              r_s1_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v   <= 1'b0;
            r_s1_y   <= '0;
            r_s1_dcb <= '0;
            r_s1_dcr <= '0;
            r_s1_sop <= 1'b0;
            r_s1_eop <= 1'b0;
        end else if (w_adv_s1) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_y   <= in_y;
                r_s1_dcb <= $signed({1'b0, in_cb}) - 9'sd128;
                r_s1_dcr <= $signed({1'b0, in_cr}) - 9'sd128;
                r_s1_sop <= in_sop;
                r_s1_eop <= in_eop;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: scaled luma and the four chroma products
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_y_x;
    logic signed [W-1:0] w_dcb_x;
    logic signed [W-1:0] w_dcr_x;

    assign w_y_x   = {{(W-8){1'b0}}, r_s1_y};
    assign w_dcb_x = {{(W-9){r_s1_dcb[8]}}, r_s1_dcb};
    assign w_dcr_x = {{(W-9){r_s1_dcr[8]}}, r_s1_dcr};

    logic signed [W-1:0] r_s2_y;
    logic signed [W-1:0] r_s2_pr;
    logic signed [W-1:0] r_s2_pgb;
    logic signed [W-1:0] r_s2_pgr;
    logic signed [W-1:0] r_s2_pb;
    logic                r_s2_sop;
    logic                r_s2_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_v   <= 1'b0;
            r_s2_y   <= '0;
            r_s2_pr  <= '0;
            r_s2_pgb <= '0;
            r_s2_pgr <= '0;
            r_s2_pb  <= '0;
            r_s2_sop <= 1'b0;
            r_s2_eop <= 1'b0;
        end else if (w_adv_s2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_y   <= w_y_x <<< FRAC_BITS;
                r_s2_pr  <= w_dcr_x * c_KR;
                r_s2_pgb <= w_dcb_x * c_KGB;
                r_s2_pgr <= w_dcr_x * c_KGR;
                r_s2_pb  <= w_dcb_x * c_KB;
                r_s2_sop <= r_s1_sop;
                r_s2_eop <= r_s1_eop;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: sum, round half-up, arithmetic shift, saturate
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_sum_r;
    logic signed [W-1:0] w_sum_g;
    logic signed [W-1:0] w_sum_b;
    rgb888_t             w_rgb;

    assign w_sum_r = r_s2_y + r_s2_pr + c_HALF;
    assign w_sum_g = r_s2_y - r_s2_pgb - r_s2_pgr + c_HALF;
    assign w_sum_b = r_s2_y + r_s2_pb + c_HALF;

    assign w_rgb.r = f_sat(w_sum_r >>> FRAC_BITS);
    assign w_rgb.g = f_sat(w_sum_g >>> FRAC_BITS);
    assign w_rgb.b = f_sat(w_sum_b >>> FRAC_BITS);

    rgb888_t r_rgb;
    logic    r_out_sop;
    logic    r_out_eop;
    logic    r_frame_done;

    // Data only loads with a valid pixel, so the outputs stay frozen both
    // while stalled and while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_v   <= 1'b0;
            r_rgb     <= '0;
            r_out_sop <= 1'b0;
            r_out_eop <= 1'b0;
        end else if (w_adv_out) begin
            r_out_v <= r_s2_v;
            if (r_s2_v) begin
                r_rgb     <= w_rgb;
                r_out_sop <= r_s2_sop;
                r_out_eop <= r_s2_eop;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_out_v && out_ready && r_out_eop;
        end
    end

    assign out_valid  = r_out_v;
    assign out_rgb    = r_rgb;
    assign out_sop    = r_out_sop;
    assign out_eop    = r_out_eop;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------
    // Framing checker on the input handshake
    // ------------------------------------------------------------------
    ycc_frame_checker #(
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_frame_checker (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_accept    (w_in_fire),
        .i_sop       (in_sop),
        .i_eop       (in_eop),
        .i_err_clr   (err_clr),
        .o_frame_err (frame_err)
    );

endmodule
`default_nettype wire
